// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial bit-at-a-time arithmetic blocks.
// Holds the controller state encoding and the default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must be able to hold WIDTH itself, hence the extra bit.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_sub_4bit_fs.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_4bit.sv
// Serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// through a single full-subtractor cell, then publishes diff/bout.
module serial_sub_4bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_bits(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             br_q, br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] part_shift;

  fs u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (br_next)
  );

  assign part_shift = {bit_d, part_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    part_d  = part_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        part_d = part_shift;
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        // Last bit: publish straight from the cell so no extra cycle is spent.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = part_shift;
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      part_q  <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      part_q  <= part_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_4bit.sv
// Scoreboard bench for serial_sub_4bit at WIDTH=4 and WIDTH=8.
// Expected {bout,diff} pushed on start, popped when done is seen.
module tb_serial_sub_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, bin;
  logic [3:0] a, b;
  logic       busy, done, bout;
  logic [3:0] diff;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int doneCount8  = 0;
  int cyc         = 0;
  int lastDoneCyc = 0;
  int contBase    = 0;
  logic contMode  = 1'b0;

  logic [4:0] expQ[$];
  logic [8:0] expQ8[$];

  always #5 clk = ~clk;

  serial_sub_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub_4bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] refSub4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] r;
    r = {1'b0, x} - {1'b0, y} - {4'd0, c};
    return r;
  endfunction

  function automatic logic [8:0] refSub8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y} - {8'd0, c};
    return r;
  endfunction

  // Scoreboard monitors sample 2 time units after each rising edge.
  always @(posedge clk) begin : mon4
    logic [4:0] e;
    #2;
    cyc++;
    if (rst_n && done) begin
      doneCount++;
      if (contMode && doneCount > contBase + 1)
        checkOutput("contPeriod", 32'(cyc - lastDoneCyc), 32'd6);
      lastDoneCyc = cyc;
      if (expQ.size() == 0) begin
        checkOutput("spuriousDone", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("diff", 32'(diff), 32'(e[3:0]));
        checkOutput("bout", 32'(bout), 32'(e[4]));
      end
    end
  end

  always @(posedge clk) begin : mon8
    logic [8:0] e;
    #2;
    if (rst_n && done8) begin
      doneCount8++;
      if (expQ8.size() == 0) begin
        checkOutput("spuriousDone8", 32'd1, 32'd0);
      end else begin
        e = expQ8.pop_front();
        checkOutput("diff8", 32'(diff8), 32'(e[7:0]));
        checkOutput("bout8", 32'(bout8), 32'(e[8]));
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
    int cycles;
    int prev;
    prev   = doneCount;
    cycles = 0;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    expQ.push_back(refSub4(ta, tb, tbin));
    while (doneCount == prev && cycles < 20) begin
      @(posedge clk);
      #1;
      if (cycles == 0) begin
        start = 1'b0;
        a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom);
      end
      #2;
      cycles++;
      if (cycles == 2) checkOutput("busyMid", 32'(busy), 32'd1);
    end
    checkOutput("latency", 32'(cycles), 32'd6);
  endtask

  task automatic applyStimulus8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    int cycles;
    int prev;
    prev   = doneCount8;
    cycles = 0;
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    expQ8.push_back(refSub8(ta, tb, tbin));
    while (doneCount8 == prev && cycles < 30) begin
      @(posedge clk);
      #1;
      if (cycles == 0) begin
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      #2;
      cycles++;
    end
    checkOutput("latency8", 32'(cycles), 32'd10);
  endtask

  initial begin
    int prev;
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstDiff", 32'(diff), 32'd0);
    checkOutput("rstBout", 32'(bout), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    rst_n = 1'b1;

    applyStimulus(4'd9, 4'd5, 1'b0);
    applyStimulus(4'd5, 4'd9, 1'b0);
    applyStimulus(4'd0, 4'd0, 1'b1);
    applyStimulus(4'd15, 4'd15, 1'b0);

    // Start requests during RUN and DONE must be dropped.
    prev = doneCount;
    a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
    expQ.push_back(refSub4(4'd9, 4'd5, 1'b0));
    @(posedge clk);
    #1;
    a = 4'd1; b = 4'd2;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("singleDone", 32'(doneCount - prev), 32'd1);
    applyStimulus(4'd1, 4'd2, 1'b0);

    // Reset in the middle of RUN.
    a = 4'd9; b = 4'd5; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstDiff", 32'(diff), 32'd0);
    checkOutput("midRstBout", 32'(bout), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    prev = doneCount;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #3;
    checkOutput("noDoneAfterRst", 32'(doneCount - prev), 32'd0);
    applyStimulus(4'd7, 4'd3, 1'b0);

    // Start held high: captures every sixth edge.
    contBase = doneCount;
    contMode = 1'b1;
    for (int i = 0; i < 36; i++) begin
      a = 4'($urandom); b = 4'($urandom); bin = 1'($urandom); start = 1'b1;
      if (i % 6 == 0) expQ.push_back(refSub4(a, b, bin));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    contMode = 1'b0;
    checkOutput("contDones", 32'(doneCount - contBase), 32'd6);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          applyStimulus(4'(x), 4'(y), 1'(c));

    applyStimulus8(8'd0, 8'd255, 1'b1);
    applyStimulus8(8'd255, 8'd0, 1'b0);
    for (int i = 0; i < 40; i++)
      applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom));

    repeat (3) @(posedge clk);
    #3;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("queueEmpty8", 32'(expQ8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
